// File: rtl/fb_pkg.sv
// Framebuffer geometry, pixel width and writer state encoding, shared by the
// writer and the display path.
package fb_pkg;

    localparam int unsigned H_RES    = 320;
    localparam int unsigned V_RES    = 240;
    localparam int unsigned ADDR_W   = 17;
    localparam int unsigned FB_DEPTH = H_RES * V_RES;
    localparam int unsigned PIX_W    = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_CLEAR  = 2'd2
    } fb_state_e;

endpackage

// File: rtl/fb_writer_if.sv
// Pixel stream input plus framebuffer write port of the framebuffer writer.
interface fb_writer_if #(
    parameter int unsigned ADDR_W = fb_pkg::ADDR_W
) ();

    logic                      in_valid;
    logic                      in_ready;
    logic [fb_pkg::PIX_W-1:0]  in_data;
    logic                      in_sof;
    logic                      fb_we;
    logic [ADDR_W-1:0]         fb_addr;
    logic [fb_pkg::PIX_W-1:0]  fb_wdata;

    // master: pixel source / framebuffer observer; slave: the writer
    modport master (
        output in_valid, in_data, in_sof,
        input  in_ready, fb_we, fb_addr, fb_wdata
    );

    modport slave (
        input  in_valid, in_data, in_sof,
        output in_ready, fb_we, fb_addr, fb_wdata
    );

endinterface

// File: rtl/fb_xy_counter.sv
// Raster position counter: x/y with line and frame wrap, plus a linear address
// kept in step by increment so no multiplier is needed.
module fb_xy_counter #(
    parameter int unsigned H_RES  = fb_pkg::H_RES,
    parameter int unsigned V_RES  = fb_pkg::V_RES,
    parameter int unsigned ADDR_W = fb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam int unsigned XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int unsigned YW = (V_RES > 1) ? $clog2(V_RES) : 1;

    logic [XW-1:0]     x_q, x_d, bx;
    logic [YW-1:0]     y_q, y_d, by;
    logic [ADDR_W-1:0] a_q, a_d, ba;

    // restart rebases to pixel 0; with step also set, that pixel is consumed
    always_comb begin
        bx  = restart ? '0 : x_q;
        by  = restart ? '0 : y_q;
        ba  = restart ? '0 : a_q;
        x_d = bx;
        y_d = by;
        a_d = ba;
        if (step) begin
            if (bx == XW'(H_RES - 1)) begin
                x_d = '0;
                if (by == YW'(V_RES - 1)) begin
                    y_d = '0;
                    a_d = '0;
                end else begin
                    y_d = by + YW'(1);
                    a_d = ba + ADDR_W'(1);
                end
            end else begin
                x_d = bx + XW'(1);
                a_d = ba + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
            a_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            a_q <= a_d;
        end
    end

    assign addr = a_q;
    assign last = (x_q == XW'(H_RES - 1)) && (y_q == YW'(V_RES - 1));

endmodule

// File: rtl/fb_writer.sv
// Streams RGB444 pixels into a linear framebuffer and, when built with
// FB_WRITER_CLEAR_EN, fills the whole buffer with a colour on request.
module fb_writer
    import fb_pkg::*;
#(
    parameter int unsigned H_RES  = fb_pkg::H_RES,
    parameter int unsigned V_RES  = fb_pkg::V_RES,
    parameter int unsigned ADDR_W = fb_pkg::ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    fb_writer_if.slave       bus,
    input  logic             clear_req,
    input  logic [PIX_W-1:0] clear_color,
    output logic             busy,
    output logic             frame_done,
    output logic             sof_err
);

    fb_state_e         state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PIX_W-1:0]  data_q, data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cnt_restart, cnt_step, cnt_last;
    logic [ADDR_W-1:0] cnt_addr;
    logic              clr_c, ready_c, accept_c;

`ifdef FB_WRITER_CLEAR_EN
    logic [PIX_W-1:0]  color_q, color_d;
    assign clr_c = clear_req;
`else
    logic              unused_clear;
    assign clr_c        = 1'b0;
    assign unused_clear = ^{clear_req, clear_color};
`endif

    // a clear request in IDLE takes the cycle away from the pixel stream
    assign ready_c  = !rst && (((state_q == ST_IDLE) && !clr_c) || (state_q == ST_STREAM));
    assign accept_c = bus.in_valid && ready_c;

    fb_xy_counter #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .restart (cnt_restart),
        .step    (cnt_step),
        .addr    (cnt_addr),
        .last    (cnt_last)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        cnt_restart = 1'b0;
        cnt_step    = 1'b0;
`ifdef FB_WRITER_CLEAR_EN
        color_d     = color_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef FB_WRITER_CLEAR_EN
                if (clear_req) begin
                    color_d     = clear_color;
                    cnt_restart = 1'b1;
                    state_d     = ST_CLEAR;
                end else
`endif
                if (accept_c && bus.in_sof) begin
                    we_d        = 1'b1;
                    addr_d      = '0;
                    data_d      = bus.in_data;
                    cnt_restart = 1'b1;
                    cnt_step    = 1'b1;
                    state_d     = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (accept_c) begin
                    we_d     = 1'b1;
                    data_d   = bus.in_data;
                    cnt_step = 1'b1;
                    if (bus.in_sof) begin
                        addr_d      = '0;
                        cnt_restart = 1'b1;
                        err_d       = 1'b1;
                    end else begin
                        addr_d = cnt_addr;
                        if (cnt_last) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
`ifdef FB_WRITER_CLEAR_EN
            ST_CLEAR: begin
                we_d     = 1'b1;
                addr_d   = cnt_addr;
                data_d   = color_q;
                cnt_step = 1'b1;
                if (cnt_last) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef FB_WRITER_CLEAR_EN
            color_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef FB_WRITER_CLEAR_EN
            color_q <= color_d;
`endif
        end
    end

    assign bus.in_ready = ready_c;
    assign bus.fb_we    = we_q;
    assign bus.fb_addr  = addr_q;
    assign bus.fb_wdata = data_q;
    assign busy         = (state_q != ST_IDLE);
    assign frame_done   = done_q;
    assign sof_err      = err_q;

endmodule

// File: doc/fb_writer.md
FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 Parameters: H_RES, default 320, pixels per line; V_RES, default 240, lines per frame; ADDR_W, default 17, framebuffer address width.
REQ-002 clk  input  1  pixel/system clock.
REQ-003 rst  input  1  reset; synchronous, active-high; clock clk.
REQ-004 in_valid  input  1  upstream pixel beat valid.
REQ-005 in_ready  output  1  block accepts the beat this cycle.
REQ-006 in_data  input  12  pixel RGB444, {r[11:8], g[7:4], b[3:0]}.
REQ-007 in_sof  input  1  beat is pixel (0,0) of a frame.
REQ-008 clear_req  input  1  one-cycle request to fill the framebuffer.
REQ-009 clear_color  input  12  fill value, sampled with clear_req.
REQ-010 fb_we  output  1  framebuffer write strobe.
REQ-011 fb_addr  output  ADDR_W  write address, y*H_RES+x.
REQ-012 fb_wdata  output  12  write data.
REQ-013 busy  output  1  high when state is not IDLE.
REQ-014 frame_done  output  1  one-cycle pulse after the last write of a frame or clear.
REQ-015 sof_err  output  1  one-cycle pulse on an in_sof beat received mid-frame.

Function
REQ-016 A beat is accepted when in_valid and in_ready are both high; fb_we, fb_addr, fb_wdata, frame_done and sof_err are registered.
REQ-017 Latency: fb_we asserts exactly one cycle after the accepting edge, carrying that beat's data and address.
REQ-018 States: IDLE, STREAM, CLEAR.
REQ-019 IDLE: in_ready=1; an accepted beat with in_sof=0 is dropped with no write; an accepted beat with in_sof=1 writes address 0 and moves to STREAM.
REQ-020 STREAM: in_ready=1; x counts 0..H_RES-1, y counts 0..V_RES-1; the address increments by 1 per accepted beat with no multiplier.
REQ-021 STREAM: when x=H_RES-1, x wraps to 0 and y increments.
REQ-022 STREAM: an accepted beat at x=H_RES-1, y=V_RES-1 writes address H_RES*V_RES-1, pulses frame_done together with that fb_we, and returns to IDLE.
REQ-023 STREAM: an in_sof beat restarts the frame at address 0, writes that beat, pulses sof_err with that write, and stays in STREAM.
REQ-024 STREAM: clear_req is ignored.
REQ-025 IDLE: clear_req latches clear_color and moves to CLEAR.
REQ-026 IDLE: clear_req has priority over an in_valid beat in the same cycle; the beat is not accepted (in_ready=0 that cycle).
REQ-027 CLEAR: in_ready=0; fb_we=1 every cycle for addresses 0..H_RES*V_RES-1 in order, with the latched color.
REQ-028 CLEAR: frame_done pulses with the final write, then the block returns to IDLE.
REQ-029 fb_addr and fb_wdata hold their last values when fb_we=0.

Reset
REQ-030 While rst is high: state=IDLE, x=y=0, fb_we=0, fb_addr=0, fb_wdata=0, frame_done=0, sof_err=0, busy=0, latched color=0.
REQ-031 rst mid-STREAM or mid-CLEAR aborts the operation; no further writes are issued; frame_done does not pulse.
REQ-032 in_ready is 0 while rst is high.

Configuration
REQ-033 Macro FB_WRITER_CLEAR_EN: when defined, CLEAR and clear_req/clear_color behave as specified.
REQ-034 When FB_WRITER_CLEAR_EN is undefined: CLEAR logic is absent, clear_req and clear_color are ignored, ports remain present.

Structure
REQ-035 Shared package fb_pkg holds H_RES, V_RES, ADDR_W, FB_DEPTH (=H_RES*V_RES) and the state enum; the display path reuses these.
REQ-036 One sub-module, fb_xy_counter, holds the x/y/address counter with wrap and restart inputs; STREAM and CLEAR share it.

Verification
REQ-037 Idle drop: 3 beats with in_sof=0, then an sof beat of 0xF00 -> no writes for the first 3; one write to addr 0, data 0xF00; busy=1.
REQ-038 Full frame: 76800 beats, data=addr[11:0], in_valid toggling randomly -> addr 319 followed by 320; last write to addr 76799; frame_done coincides with it; back in IDLE.
REQ-039 Mid-frame sof: sof at beat 1000 -> sof_err pulse; that write goes to addr 0; the next frame completes at 76799.
REQ-040 Clear: clear_req with clear_color=0x0A5 and in_valid=1 in the same cycle -> in_ready=0; 76800 consecutive writes of 0x0A5; frame_done on addr 76799.
REQ-041 Reset mid-clear: rst at write 500 for 1 cycle -> fb_we=0 next cycle; IDLE; no frame_done.
REQ-042 Macro off: build without FB_WRITER_CLEAR_EN, pulse clear_req -> no writes; state stays IDLE.
